jt12_timer_ctrl: RTL and testbench

Timer A/B controller for the OPN core; consumes the timer tick enable produced by the clock divider (clk_en_timers) and sequences both chip timers.
- Timer A: 10-bit up-counter.
- Timer B: 8-bit up-counter behind a /16 prescaler.
- Handles load/start, overflow flags, flag clear, the CSM overflow pulse and the active-low IRQ line.
- Sits between the register file (control writes) and the CPU bus / CSM key-on logic (outputs).

---
 rtl/jt12_timer_pkg.sv | 13 +
 rtl/jt12_timer_cnt.sv | 85 ++++++++
 rtl/jt12_timer_ctrl.sv | 64 ++++++
 tb/tb_jt12_timer_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jt12_timer_pkg.sv
// Shared constants for the OPN timer block: counter widths, Timer B
// prescaler ratio and status register bit positions.
package jt12_timer_pkg;

  localparam int unsigned CNTA_W     = 10;
  localparam int unsigned CNTB_W     = 8;
  localparam int unsigned PRESA      = 1;
  localparam int unsigned PRESB      = 16;

  localparam int unsigned FLAG_A_BIT = 0;
  localparam int unsigned FLAG_B_BIT = 1;

endpackage

// File: rtl/jt12_timer_cnt.sv
// One chip timer: start-edge detect on the run bit, optional power-of-two
// prescaler, up-counter that reloads its preset on all-ones overflow,
// registered overflow pulse and sticky overflow flag.
module jt12_timer_cnt #(
  parameter int unsigned W    = 10,
  parameter int unsigned PRES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic [W-1:0] value,
  input  logic         load,
  input  logic         flagen,
  input  logic         clr,
  output logic         flag,
  output logic         flag_nxt,
  output logic         ovf
);

  logic [W-1:0] cnt;
  logic         load_q;
  logic         start;
  logic         run_tick;
  logic         pres_full;
  logic         cnt_tick;
  logic         overflow;

  // Start edge wins over a coincident tick; only a running timer counts
  always_comb begin
    start    = load & ~load_q;
    run_tick = load & ~start & cen;
    cnt_tick = run_tick & pres_full;
    overflow = cnt_tick & (cnt == '1);
  end

  generate
    if (PRES > 1) begin : g_pres
      localparam int unsigned PW = $clog2(PRES);
      logic [PW-1:0] pres;

      // Prescaler wraps naturally since PRES is a power of two
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pres <= '0;
        else if (start)    pres <= '0;
        else if (run_tick) pres <= pres + 1'b1;
      end

      always_comb pres_full = (pres == PW'(PRES - 1));
    end else begin : g_nopres
      always_comb pres_full = 1'b1;
    end
  endgenerate

  // Run-bit history for edge detection, sampled every clk regardless of cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_q <= 1'b0;
    else        load_q <= load;
  end

  // Counter: preset on start, increment on prescaled tick, reload on overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (start)    cnt <= value;
    else if (cnt_tick) cnt <= overflow ? value : cnt + 1'b1;
  end

  // Flag next state: a set beats a simultaneous clear so no overflow is lost
  always_comb begin
    flag_nxt = flag;
    if (overflow && flagen) flag_nxt = 1'b1;
    else if (clr)           flag_nxt = 1'b0;
  end

  // Flag and one-clk overflow pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      flag <= flag_nxt;
      ovf  <= overflow;
    end
  end

endmodule

// File: rtl/jt12_timer_ctrl.sv
// Timer A/B controller: two timer instances sharing the divider tick, plus
// the active-low IRQ line and the Timer A overflow pulse used by CSM.
module jt12_timer_ctrl
  import jt12_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [CNTA_W-1:0] value_a,
  input  logic [CNTB_W-1:0] value_b,
  input  logic              load_a,
  input  logic              load_b,
  input  logic              flagen_a,
  input  logic              flagen_b,
  input  logic              clr_a,
  input  logic              clr_b,
  output logic              flag_a,
  output logic              flag_b,
  output logic              ovf_a,
  output logic              irq_n
);

  logic [1:0] flag_nxt;
  logic       ovf_b_unused;

  jt12_timer_cnt #(
    .W    (CNTA_W),
    .PRES (PRESA)
  ) u_timer_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .value    (value_a),
    .load     (load_a),
    .flagen   (flagen_a),
    .clr      (clr_a),
    .flag     (flag_a),
    .flag_nxt (flag_nxt[FLAG_A_BIT]),
    .ovf      (ovf_a)
  );

  jt12_timer_cnt #(
    .W    (CNTB_W),
    .PRES (PRESB)
  ) u_timer_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .value    (value_b),
    .load     (load_b),
    .flagen   (flagen_b),
    .clr      (clr_b),
    .flag     (flag_b),
    .flag_nxt (flag_nxt[FLAG_B_BIT]),
    .ovf      (ovf_b_unused)
  );

  // IRQ built from the flags' next state so it changes on the same edge as the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_n <= 1'b1;
    else        irq_n <= ~(|flag_nxt);
  end

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// Directed bench for the timer A/B controller.
module tb_jt12_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic [9:0] value_a;
  logic [7:0] value_b;
  logic       load_a, load_b, flagen_a, flagen_b, clr_a, clr_b;
  logic       flag_a, flag_b, ovf_a, irq_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jt12_timer_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .value_a  (value_a),
    .value_b  (value_b),
    .load_a   (load_a),
    .load_b   (load_b),
    .flagen_a (flagen_a),
    .flagen_b (flagen_b),
    .clr_a    (clr_a),
    .clr_b    (clr_b),
    .flag_a   (flag_a),
    .flag_b   (flag_b),
    .ovf_a    (ovf_a),
    .irq_n    (irq_n)
  );

  // One clk with the given tick enable; clear pulses last exactly one clk
  task automatic step(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    cen   = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL reset_flag_a: got %b want 0", flag_a); end
    checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL reset_flag_b: got %b want 0", flag_b); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf_a: got %b want 0", ovf_a); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow_a;
    value_a  = 10'd1020;
    flagen_a = 1'b1;
    load_a   = 1'b1;
    step(1'b0);
    checks++; if (dut.u_timer_a.cnt !== 10'd1020) begin errors++; $display("FAIL ova_start_cnt: got %0d want 1020", dut.u_timer_a.cnt); end
    for (int k = 1; k <= 4; k++) begin
      repeat (11) step(1'b0);
      step(1'b1);
      checks++; if (ovf_a !== (k == 4)) begin errors++; $display("FAIL ova_pulse_tick%0d: got %b want %b", k, ovf_a, (k == 4)); end
      checks++; if (flag_a !== (k == 4)) begin errors++; $display("FAIL ova_flag_tick%0d: got %b want %b", k, flag_a, (k == 4)); end
    end
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL ova_irq_n: got %b want 0", irq_n); end
    checks++; if (dut.u_timer_a.cnt !== 10'd1020) begin errors++; $display("FAIL ova_reload_cnt: got %0d want 1020", dut.u_timer_a.cnt); end
    step(1'b0);
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ova_pulse_width: got %b want 0", ovf_a); end
    checks++; if (flag_a !== 1'b1) begin errors++; $display("FAIL ova_flag_sticky: got %b want 1", flag_a); end
  endtask

  task automatic test_clr_collision;
    repeat (3) step(1'b1);
    clr_a = 1'b1;
    step(1'b1);
    checks++; if (flag_a !== 1'b1) begin errors++; $display("FAIL clr_collide_flag: got %b want 1", flag_a); end
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL clr_collide_ovf: got %b want 1", ovf_a); end
    clr_a = 1'b1;
    step(1'b0);
    checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL clr_late_flag: got %b want 0", flag_a); end
    checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL clr_late_flag_b: got %b want 0", flag_b); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL clr_late_irq_n: got %b want 1", irq_n); end
  endtask

  task automatic test_no_flagen;
    load_a = 1'b0;
    step(1'b0);
    value_a  = 10'd1022;
    flagen_a = 1'b0;
    load_a   = 1'b1;
    step(1'b0);
    checks++; if (dut.u_timer_a.cnt !== 10'd1022) begin errors++; $display("FAIL nofl_start_cnt: got %0d want 1022", dut.u_timer_a.cnt); end
    for (int k = 1; k <= 6; k++) begin
      step(1'b1);
      checks++; if (ovf_a !== (k % 2 == 0)) begin errors++; $display("FAIL nofl_ovf_tick%0d: got %b want %b", k, ovf_a, (k % 2 == 0)); end
      checks++; if (flag_a !== 1'b0) begin errors++; $display("FAIL nofl_flag_tick%0d: got %b want 0", k, flag_a); end
      checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL nofl_irq_tick%0d: got %b want 1", k, irq_n); end
    end
  endtask

  task automatic test_stop_hold;
    logic seen_ovf;
    load_a = 1'b0;
    step(1'b0);
    value_a  = 10'd990;
    flagen_a = 1'b1;
    load_a   = 1'b1;
    step(1'b0);
    repeat (10) step(1'b1);
    checks++; if (dut.u_timer_a.cnt !== 10'd1000) begin errors++; $display("FAIL stop_reach_cnt: got %0d want 1000", dut.u_timer_a.cnt); end
    load_a   = 1'b0;
    value_a  = 10'd500;
    seen_ovf = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(1'b1);
      if (ovf_a) seen_ovf = 1'b1;
    end
    checks++; if (dut.u_timer_a.cnt !== 10'd1000) begin errors++; $display("FAIL stop_hold_cnt: got %0d want 1000", dut.u_timer_a.cnt); end
    checks++; if (seen_ovf !== 1'b0) begin errors++; $display("FAIL stop_no_ovf: got %b want 0", seen_ovf); end
    load_a = 1'b1;
    step(1'b1);
    checks++; if (dut.u_timer_a.cnt !== 10'd500) begin errors++; $display("FAIL stop_restart_cnt: got %0d want 500", dut.u_timer_a.cnt); end
    step(1'b1);
    checks++; if (dut.u_timer_a.cnt !== 10'd501) begin errors++; $display("FAIL stop_count_on: got %0d want 501", dut.u_timer_a.cnt); end
  endtask

  task automatic test_timer_b;
    int n;
    load_a = 1'b0;
    step(1'b0);
    value_b  = 8'd254;
    flagen_b = 1'b1;
    load_b   = 1'b1;
    step(1'b0);
    n = 0;
    while (n < 200 && flag_b !== 1'b1) begin
      step(1'b1);
      n++;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL tb_first_ticks: got %0d want 32", n); end
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL tb_irq_n: got %b want 0", irq_n); end
    clr_b = 1'b1;
    step(1'b0);
    checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL tb_clr_flag: got %b want 0", flag_b); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL tb_clr_irq_n: got %b want 1", irq_n); end
    while (n < 200 && flag_b !== 1'b1) begin
      step(1'b1);
      n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL tb_second_ticks: got %0d want 64", n); end
  endtask

  task automatic test_async_reset;
    logic seen_ovf;
    value_a = 10'd700;
    load_a  = 1'b1;
    step(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (flag_b !== 1'b0) begin errors++; $display("FAIL arst_flag_b: got %b want 0", flag_b); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL arst_irq_n: got %b want 1", irq_n); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL arst_ovf_a: got %b want 0", ovf_a); end
    checks++; if (dut.u_timer_a.cnt !== 10'd0) begin errors++; $display("FAIL arst_cnt_a: got %0d want 0", dut.u_timer_a.cnt); end
    checks++; if (dut.u_timer_b.cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt_b: got %0d want 0", dut.u_timer_b.cnt); end
    load_a = 1'b0;
    load_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen_ovf = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1);
      if (ovf_a) seen_ovf = 1'b1;
    end
    checks++; if (dut.u_timer_a.cnt !== 10'd0) begin errors++; $display("FAIL arst_idle_cnt_a: got %0d want 0", dut.u_timer_a.cnt); end
    checks++; if (dut.u_timer_b.cnt !== 8'd0) begin errors++; $display("FAIL arst_idle_cnt_b: got %0d want 0", dut.u_timer_b.cnt); end
    checks++; if (seen_ovf !== 1'b0) begin errors++; $display("FAIL arst_idle_ovf: got %b want 0", seen_ovf); end
    value_a = 10'd1023;
    load_a  = 1'b1;
    step(1'b0);
    step(1'b1);
    checks++; if (ovf_a !== 1'b1) begin errors++; $display("FAIL arst_relaunch_ovf: got %b want 1", ovf_a); end
    checks++; if (flag_a !== 1'b1) begin errors++; $display("FAIL arst_relaunch_flag: got %b want 1", flag_a); end
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL arst_relaunch_irq_n: got %b want 0", irq_n); end
  endtask

  initial begin
    rst_n    = 1'b0;
    cen      = 1'b0;
    value_a  = '0;
    value_b  = '0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    flagen_a = 1'b0;
    flagen_b = 1'b0;
    clr_a    = 1'b0;
    clr_b    = 1'b0;
    test_reset;
    test_overflow_a;
    test_clr_collision;
    test_no_flagen;
    test_stop_hold;
    test_timer_b;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
